mem_access_unit: RTL and testbench

//  MEM-stage data-memory access unit; consumes the EX/MEM pipeline register outputs.

---
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
// Turns EX/MEM load/store control into a req/ack memory transaction with
// byte-lane steering, write byte enables and load sign/zero extension.
// stallm holds the upstream pipeline while a legal access is in progress.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | sample MEM-stage access, launch request or flag misalign
//   WAIT  | dReq held, waiting for dAck or timeout
//   DONE  | one cycle with stallm low so the pipeline advances
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWrtm,
  input  logic        readm,
  input  logic [2:0]  funct3m,
  input  logic [31:0] aluRsltm,
  input  logic [31:0] wrtDm,
  output logic        dReq,
  output logic        dWe,
  output logic [31:0] dAddr,
  output logic [31:0] dWdata,
  output logic [3:0]  dBe,
  input  logic [31:0] dRdata,
  input  logic        dAck,
  output logic [31:0] rdData,
  output logic        rdValid,
  output logic        stallm,
  output logic        misalign,
  output logic        busErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_lane;
  logic [2:0]  r_f3;
  logic        r_load;

  logic        w_store;
  logic        w_load;
  logic        w_access;
  logic        w_legal;
  logic        w_aligned;
  logic        w_go;
  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // A store takes priority when both strobes are set.
  assign w_store  = memWrtm;
  assign w_load   = readm & ~memWrtm;
  assign w_access = w_store | w_load;

  // Classify funct3 legality and address alignment for the incoming access.
  always_comb begin
    w_legal = 1'b0;
    if (w_store) begin
      w_legal = (funct3m == 3'd0) || (funct3m == 3'd1) || (funct3m == 3'd2);
    end else if (w_load) begin
      w_legal = (funct3m == 3'd0) || (funct3m == 3'd1) || (funct3m == 3'd2) ||
                (funct3m == 3'd4) || (funct3m == 3'd5);
    end
    case (funct3m[1:0])
      2'b01:   w_aligned = ~aluRsltm[0];
      2'b10:   w_aligned = (aluRsltm[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_go  = (r_state == IDLE) & w_access & w_legal & w_aligned;
  assign w_bad = (r_state == IDLE) & w_access & ~(w_legal & w_aligned);

  // Stall must already be high in the IDLE cycle that launches the request,
  // otherwise the instruction would leave MEM before its access completes.
  assign stallm = ~rst & (w_go | (r_state == WAIT));

  // Store byte enables and lane-replicated write data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'd0;
    if (w_store) begin
      case (funct3m[1:0])
        2'b00: begin
          w_be    = 4'b0001 << aluRsltm[1:0];
          w_wdata = {4{wrtDm[7:0]}};
        end
        2'b01: begin
          w_be    = aluRsltm[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wrtDm[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wrtDm;
        end
      endcase
    end
  end

  // Extract and extend the load result from the returned word.
  always_comb begin
    w_shift = dRdata >> {r_lane, 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = r_lane[1] ? dRdata[31:16] : dRdata[15:0];
    case (r_f3)
      3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_ext = {24'd0, w_byte};
      3'd1:    w_ext = {{16{w_half[15]}}, w_half};
      3'd5:    w_ext = {16'd0, w_half};
      default: w_ext = dRdata;
    endcase
  end

  // Access sequencer with registered bus and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_lane   <= 2'd0;
      r_f3     <= 3'd0;
      r_load   <= 1'b0;
      dReq     <= 1'b0;
      dWe      <= 1'b0;
      dAddr    <= 32'd0;
      dWdata   <= 32'd0;
      dBe      <= 4'd0;
      rdData   <= 32'd0;
      rdValid  <= 1'b0;
      misalign <= 1'b0;
      busErr   <= 1'b0;
    end else begin
      rdValid  <= 1'b0;
      misalign <= 1'b0;
      busErr   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go) begin
            dReq    <= 1'b1;
            dWe     <= w_store;
            dAddr   <= {aluRsltm[31:2], 2'b00};
            dWdata  <= w_wdata;
            dBe     <= w_be;
            r_lane  <= aluRsltm[1:0];
            r_f3    <= funct3m;
            r_load  <= w_load;
            r_cnt   <= 8'd1;
            r_state <= WAIT;
          end else if (w_bad) begin
            misalign <= 1'b1;
            if (w_load) begin
              rdData  <= 32'd0;
              rdValid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (dAck) begin
            dReq <= 1'b0;
            if (r_load) begin
              rdData  <= w_ext;
              rdValid <= 1'b1;
            end
            r_state <= DONE;
          end else if (r_cnt == 8'(MAX_WAIT)) begin
            dReq   <= 1'b0;
            busErr <= 1'b1;
            if (r_load) begin
              rdData  <= 32'd0;
              rdValid <= 1'b1;
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_cnt   <= 8'd0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of load/store accesses
// plus a hand-written reset-during-WAIT sequence.
module tb_mem_access_unit;

  localparam int unsigned TB_MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        memWrtm;
  logic        readm;
  logic [2:0]  funct3m;
  logic [31:0] aluRsltm;
  logic [31:0] wrtDm;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [3:0]  dBe;
  logic [31:0] dRdata;
  logic        dAck;
  logic [31:0] rdData;
  logic        rdValid;
  logic        stallm;
  logic        misalign;
  logic        busErr;

  int checks;
  int failures;

  mem_access_unit #(.MAX_WAIT(TB_MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .memWrtm(memWrtm), .readm(readm), .funct3m(funct3m),
    .aluRsltm(aluRsltm), .wrtDm(wrtDm), .dReq(dReq), .dWe(dWe), .dAddr(dAddr),
    .dWdata(dWdata), .dBe(dBe), .dRdata(dRdata), .dAck(dAck), .rdData(rdData),
    .rdValid(rdValid), .stallm(stallm), .misalign(misalign), .busErr(busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ack_at: WAIT cycle (1-based) in which dAck is pulsed; 0 = never (timeout)
  typedef struct {
    logic        we;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rdd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    memWrtm  = 1'b0;
    readm    = 1'b0;
    funct3m  = 3'd0;
    aluRsltm = 32'd0;
    wrtDm    = 32'd0;
    dAck     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   stall_cnt;
    int   wait_cyc;
    int   cyc;
    int   exp_wait;
    bit   done;
    logic is_load;
    is_load = v.rd & ~v.we;
    @(negedge clk);
    memWrtm  = v.we;
    readm    = v.rd;
    funct3m  = v.f3;
    aluRsltm = v.addr;
    wrtDm    = v.wdata;
    dRdata   = v.rdata;
    #1;
    if (v.mis) begin
      chk($sformatf("v%0d_stall_mis", idx), {31'd0, stallm}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_misalign", idx), {31'd0, misalign}, 32'd1);
      chk($sformatf("v%0d_dReq_mis", idx), {31'd0, dReq}, 32'd0);
      chk($sformatf("v%0d_rdValid_mis", idx), {31'd0, rdValid}, {31'd0, is_load});
      chk($sformatf("v%0d_rdData_mis", idx), rdData, v.rdd);
      clear_inputs();
      @(negedge clk);
      chk($sformatf("v%0d_misalign_pulse", idx), {31'd0, misalign}, 32'd0);
      chk($sformatf("v%0d_rdValid_pulse", idx), {31'd0, rdValid}, 32'd0);
    end else begin
      chk($sformatf("v%0d_stall_idle", idx), {31'd0, stallm}, 32'd1);
      stall_cnt = 1;
      wait_cyc  = 0;
      cyc       = 0;
      done      = 0;
      while (!done && cyc < int'(TB_MAX_WAIT) + 4) begin
        @(negedge clk);
        cyc++;
        dAck = 1'b0;
        if (stallm) stall_cnt++;
        if (dReq) begin
          wait_cyc++;
          chk($sformatf("v%0d_dAddr", idx), dAddr, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d_dWe", idx), {31'd0, dWe}, {31'd0, v.we});
          chk($sformatf("v%0d_dBe", idx), {28'd0, dBe}, {28'd0, v.be});
          if (v.we) chk($sformatf("v%0d_dWdata", idx), dWdata, v.wd);
          // MEM inputs changing mid-access must not disturb the request
          aluRsltm = ~v.addr;
          wrtDm    = ~v.wdata;
          if (wait_cyc == v.ack_at) dAck = 1'b1;
        end else begin
          done = 1;
        end
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL v%0d_no_done: access still pending after %0d cycles", idx, cyc);
      end
      exp_wait = (v.ack_at != 0) ? v.ack_at : int'(TB_MAX_WAIT);
      chk($sformatf("v%0d_wait_cycles", idx), wait_cyc, exp_wait);
      chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, exp_wait + 1);
      chk($sformatf("v%0d_rdValid", idx), {31'd0, rdValid}, {31'd0, is_load});
      chk($sformatf("v%0d_busErr", idx), {31'd0, busErr}, {31'd0, v.ack_at == 0});
      chk($sformatf("v%0d_rdData", idx), rdData, v.rdd);
      chk($sformatf("v%0d_misalign0", idx), {31'd0, misalign}, 32'd0);
      clear_inputs();
      @(negedge clk);
      chk($sformatf("v%0d_rdValid_pulse", idx), {31'd0, rdValid}, 32'd0);
      chk($sformatf("v%0d_busErr_pulse", idx), {31'd0, busErr}, 32'd0);
      chk($sformatf("v%0d_dReq_idle", idx), {31'd0, dReq}, 32'd0);
      chk($sformatf("v%0d_rdData_hold", idx), rdData, v.rdd);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //              we    rd    f3    addr           wdata          rdata          ack mis   be       wd             rdd
    vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 2, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_0000, 32'h80AA_BBCC, 1, 1'b0, 4'b0000, 32'h0000_0000, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 1'b1, 3'd4, 32'h0000_0103, 32'h0000_0000, 32'h80AA_BBCC, 1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0080};
    vecs[3]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0000_1234, 32'h0000_0000, 1, 1'b0, 4'b1100, 32'h1234_1234, 32'h0000_0080};
    vecs[4]  = '{1'b0, 1'b1, 3'd5, 32'h0000_0102, 32'h0000_0000, 32'hBEEF_0000, 1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_BEEF};
    vecs[5]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0101, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
    vecs[6]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0200, 32'h0000_0000, 32'h1234_5678, 0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0101, 32'h0000_00A5, 32'h0000_0000, 3, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000};
    vecs[8]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0100, 32'h0000_0000, 32'h1234_8001, 1, 1'b0, 4'b0000, 32'h0000_0000, 32'hFFFF_8001};
    vecs[9]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0104, 32'h0000_0000, 32'h1234_5678, 4, 1'b0, 4'b0000, 32'h0000_0000, 32'h1234_5678};
    vecs[10] = '{1'b1, 1'b0, 3'd1, 32'h0000_0101, 32'h0000_BEEF, 32'h0000_0000, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h1234_5678};
    vecs[11] = '{1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h1234_5678};
    vecs[12] = '{1'b0, 1'b1, 3'd6, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
    vecs[13] = '{1'b1, 1'b1, 3'd2, 32'h0000_0108, 32'hCAFE_F00D, 32'h0000_0000, 1, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000};
    vecs[14] = '{1'b0, 1'b1, 3'd0, 32'h0000_0102, 32'h0000_0000, 32'h0055_0000, 2, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0055};

    rst    = 1'b1;
    dRdata = 32'd0;
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("rst_dReq", {31'd0, dReq}, 32'd0);
    chk("rst_stallm", {31'd0, stallm}, 32'd0);
    chk("rst_rdValid", {31'd0, rdValid}, 32'd0);
    chk("rst_rdData", rdData, 32'd0);
    chk("rst_dBe", {28'd0, dBe}, 32'd0);
    chk("rst_dAddr", dAddr, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_busErr", {31'd0, busErr}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Reset in the middle of WAIT, then a stale dAck two cycles later.
    @(negedge clk);
    readm    = 1'b1;
    funct3m  = 3'd2;
    aluRsltm = 32'h0000_0300;
    dRdata   = 32'h5555_AAAA;
    @(negedge clk);
    chk("rstwait_dReq_before", {31'd0, dReq}, 32'd1);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk("rstwait_dReq_after", {31'd0, dReq}, 32'd0);
    chk("rstwait_stallm", {31'd0, stallm}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    dAck = 1'b1;
    @(negedge clk);
    dAck = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstwait_rdValid_%0d", k), {31'd0, rdValid}, 32'd0);
      chk($sformatf("rstwait_busErr_%0d", k), {31'd0, busErr}, 32'd0);
      chk($sformatf("rstwait_dReq_%0d", k), {31'd0, dReq}, 32'd0);
      chk($sformatf("rstwait_rdData_%0d", k), rdData, 32'd0);
      @(negedge clk);
    end
    run_vec(vecs[0], 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
